led_sweep_monitor: RTL
======================

Name: led_sweep_monitor

Overview:
- Reads the 8-bit one-hot "Knight Rider" LED vector produced by the light-sweep generator.
- Recovers the current LED position and sweep direction.
- Checks every step against the legal bounce sequence 7→6→…→0→1→…→7→6….
- Counts completed end-of-travel reversals and flags illegal patterns or stalled sweeps.
- Sits beside the generator on the same clock as a self-check and decode block, so board logic and benches consume position/direction rather than raw LEDs.

Parameters:
- COUNT_W, 16, width of sweep_count (saturating).
- STALL_MAX, 64, maximum consecutive sampled cycles with unchanged leds while tracking before stall is raised; 0 disables stall detection.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  sampling/monitor enable; low freezes the block.
- clear  input  1  synchronous one-cycle pulse; clears error, stall and sweep_count; state returns to IDLE.
- leds  input  8  LED vector under observation; bit 7 is the sweep start.
- pos  output  3  index of the lit LED (valid when valid=1).
- dir  output  1  0 = descending index (7→0), 1 = ascending (0→7).
- valid  output  1  high while in TRACK and pos/dir are trustworthy.
- bounce  output  1  one-cycle pulse on each reversal at index 0 or 7.
- sweep_count  output  COUNT_W  number of reversals since reset/clear; saturates at all-ones.
- error  output  1  sticky; illegal pattern or illegal step detected.
- stall  output  1  sticky; leds unchanged for more than STALL_MAX sampled cycles in TRACK.

Behaviour:
- Reset (async, reset=0):
  - State=IDLE.
  - pos=0, dir=0, valid=0, bounce=0, sweep_count=0, error=0, stall=0.
  - Input register leds_q=0; stall counter=0.
- Sampling and latency:
  - When enable=1, leds is registered into leds_q each rising edge.
  - The FSM evaluates leds_q against the previously stored position.
  - A change on leds sampled at edge k is reflected on the outputs after edge k+1, i.e. 2-cycle latency.
- enable=0: leds_q, FSM state, all outputs and counters hold. bounce is forced to 0.
- Legality:
  - leds_q is "legal-hot" if exactly one bit is set.
  - leds_q=0 is "idle".
  - Anything else is illegal.
  - An unchanged leds_q is always legal, whatever the hold length; only the stall rule applies to it.
- IDLE state:
  - idle → stay in IDLE.
  - legal-hot → SYNC; pos=index.
  - illegal → FAULT.
- SYNC state (position known, direction unknown):
  - unchanged → stay in SYNC.
  - idle → IDLE.
  - legal-hot with |Δ|=1 → TRACK; pos=new index; dir=1 if new>old, else dir=0.
  - If the new index is 0 or 7 the reversal rule below applies.
  - any other change → FAULT.
- TRACK state: valid=1.
  - The expected next index is pos−1 when dir=0, pos+1 when dir=1.
  - unchanged → stay; the stall counter increments.
  - expected index → pos updated; stall counter cleared.
  - On arriving at index 0 with dir=0: dir becomes 1 in the same update, bounce pulses, sweep_count increments.
  - On arriving at index 7 with dir=1: dir becomes 0 in the same update, bounce pulses, sweep_count increments.
  - idle → IDLE (generator reset observed); valid drops; error is not set.
  - any other value → FAULT.
- FAULT state:
  - error=1, valid=0.
  - Exits to IDLE only on clear, or on idle leds_q.
  - error stays set until clear or reset.
- Stall detection:
  - Active only when STALL_MAX≠0.
  - When the stall counter exceeds STALL_MAX, stall=1 (sticky). State remains TRACK.
  - The stall counter saturates and is cleared on any accepted step, on clear, and on leaving TRACK.
- sweep_count saturates at 2^COUNT_W−1. bounce still pulses after saturation.
- Simultaneous events:
  - clear has priority over any FSM transition in the same cycle.
  - A stall and an illegal step in the same cycle set both flags.
  - reset at any time wins immediately (async).

Test Plan:
- Reset, then legal sweep 0x80,0x40,…,0x01,0x02,…,0x80 with each value held 5 cycles → pos follows 7..0..7; dir=0 then 1 after index 0, back to 0 after 7; bounce pulses twice; sweep_count=2; error=0.
- Skip step: in TRACK at 0x10 with dir=0, drive 0x04 → error=1 and valid=0 two edges later; clear pulse → error=0, IDLE.
- Double-hot: drive 0x18 from IDLE → FAULT, error=1; drive 0x00 → IDLE; error still 1 until clear.
- STALL_MAX=8: hold 0x20 in TRACK for 10 sampled cycles → stall=1, valid=1, error=0; next legal step keeps stall=1.
- Mid-sweep reset=0 for 1 cycle at pos=3 → all outputs at reset values immediately; resume at 0x80 → SYNC, then TRACK after 0x40.
- enable=0 for 20 cycles while leds changes → outputs frozen; with COUNT_W=2, 5 reversals → sweep_count=3 and 5 bounce pulses.

Source files
------------

// File: rtl/led_sweep_if.sv
// Bus between the LED sweep monitor and its consumer: control and LED sample in,
// decoded position/direction and health flags out.
interface led_sweep_if #(
    parameter int COUNT_W = 16
);
    logic               enable;
    logic               clear;
    logic [7:0]         leds;
    logic [2:0]         pos;
    logic               dir;
    logic               valid;
    logic               bounce;
    logic [COUNT_W-1:0] sweep_count;
    logic               error;
    logic               stall;

    modport master (
        output enable, clear, leds,
        input  pos, dir, valid, bounce, sweep_count, error, stall
    );

    modport slave (
        input  enable, clear, leds,
        output pos, dir, valid, bounce, sweep_count, error, stall
    );
endinterface

// File: rtl/led_sweep_monitor.sv
// Decodes a one-hot "Knight Rider" LED sweep into position/direction and checks
// every step against the legal 7..0..7 bounce sequence.
module led_sweep_monitor #(
    parameter int COUNT_W   = 16,
    parameter int STALL_MAX = 64
) (
    input logic        clk,
    input logic        reset,
    led_sweep_if.slave bus
);
    localparam int SW = $clog2(STALL_MAX + 2);
    localparam logic [SW-1:0] STALL_SAT = SW'(STALL_MAX + 1);

    typedef enum logic [1:0] {IDLE, SYNC, TRACK, FAULT} state_t;

    state_t             state;
    logic [7:0]         leds_q;
    logic [2:0]         pos;
    logic               dir, valid, bounce, error, stall;
    logic [COUNT_W-1:0] sweep_count;
    logic [SW-1:0]      stall_cnt;

    logic          hot, idle_v, same, adj, nd, at_end;
    logic [2:0]    idx;
    logic [3:0]    exp_idx;
    logic [SW-1:0] stall_inc;

    always_comb begin
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (leds_q[i]) idx = i[2:0];
        hot     = $onehot(leds_q);
        idle_v  = (leds_q == 8'h00);
        same    = (leds_q == (8'd1 << pos));
        adj     = hot && (({1'b0, idx} == {1'b0, pos} + 4'd1) ||
                          ({1'b0, idx} + 4'd1 == {1'b0, pos}));
        exp_idx = dir ? {1'b0, pos} + 4'd1 : {1'b0, pos} - 4'd1;
        // In SYNC the direction is inferred from this step; in TRACK it is already known.
        nd      = (state == SYNC) ? (idx > pos) : dir;
        at_end  = (idx == 3'd0 && !nd) || (idx == 3'd7 && nd);
        stall_inc = (stall_cnt == STALL_SAT) ? stall_cnt : stall_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            leds_q      <= '0;
            pos         <= '0;
            dir         <= 1'b0;
            valid       <= 1'b0;
            bounce      <= 1'b0;
            sweep_count <= '0;
            error       <= 1'b0;
            stall       <= 1'b0;
            stall_cnt   <= '0;
        end else if (!bus.enable) begin
            bounce <= 1'b0;
        end else begin
            leds_q <= bus.leds;
            bounce <= 1'b0;
            if (bus.clear) begin
                state       <= IDLE;
                valid       <= 1'b0;
                error       <= 1'b0;
                stall       <= 1'b0;
                sweep_count <= '0;
                stall_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (hot) begin
                            state <= SYNC;
                            pos   <= idx;
                        end else if (!idle_v) begin
                            state <= FAULT;
                            error <= 1'b1;
                        end
                    end
                    SYNC, TRACK: begin
                        if (same) begin
                            if (state == TRACK) begin
                                stall_cnt <= stall_inc;
                                if (STALL_MAX != 0 && stall_inc == STALL_SAT) stall <= 1'b1;
                            end
                        end else if ((state == SYNC) ? adj : (hot && {1'b0, idx} == exp_idx)) begin
                            state     <= TRACK;
                            valid     <= 1'b1;
                            pos       <= idx;
                            dir       <= at_end ? ~nd : nd;
                            bounce    <= at_end;
                            stall_cnt <= '0;
                            if (at_end && sweep_count != '1) sweep_count <= sweep_count + 1'b1;
                        end else if (idle_v) begin
                            state     <= IDLE;
                            valid     <= 1'b0;
                            stall_cnt <= '0;
                        end else begin
                            state     <= FAULT;
                            valid     <= 1'b0;
                            error     <= 1'b1;
                            stall_cnt <= '0;
                        end
                    end
                    FAULT: begin
                        error <= 1'b1;
                        if (idle_v) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pos         = pos;
    assign bus.dir         = dir;
    assign bus.valid       = valid;
    assign bus.bounce      = bounce;
    assign bus.sweep_count = sweep_count;
    assign bus.error       = error;
    assign bus.stall       = stall;
endmodule
